// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports (A = CPU, B = DMA/debug)
// and the single-port data memory bus of dmem_arbiter.
// slave  = arbiter side, master = requesters plus the memory itself.
interface dmem_arbiter_if;
    // Port A (CPU load/store)
    logic        a_req;
    logic        a_we;
    logic [15:0] a_addr;
    logic [15:0] a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic [15:0] a_rdata;
    logic        a_err;

    // Port B (DMA/debug)
    logic        b_req;
    logic        b_we;
    logic [15:0] b_addr;
    logic [15:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [15:0] b_rdata;
    logic        b_err;

    // Memory bus
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata, b_err,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata, b_err,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a single-port,
// MEM_WORDS x 16-bit data memory with 1-cycle synchronous read latency.
// One access is granted per cycle; the response (read data / range error)
// is returned to the owning port one cycle after its grant.
// Build option DMEM_ARB_CPU_PRIO_EN: port A has fixed priority and a 4-bit
// starvation counter forces one B grant after 15 lost cycles. Without it,
// ties are resolved round-robin on a last-grant pointer.
module dmem_arbiter #(
    parameter int   MEM_WORDS = 64,
    parameter logic RR_INIT   = 1'b1
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    typedef enum logic { ST_IDLE = 1'b0, ST_RESP = 1'b1 } state_t;
    typedef enum logic { PORT_A = 1'b0, PORT_B = 1'b1 } port_t;

    // Word indices at or above this limit fall outside the memory.
    localparam logic [15:0] WORD_LIMIT = 16'(MEM_WORDS);

    // Response pipeline: one stage, owner and kind registered at the grant.
    state_t state_q, state_d;
    port_t  owner_q, owner_d;
    logic   resp_rd_q, resp_rd_d;
    logic   resp_err_q, resp_err_d;

`ifdef DMEM_ARB_CPU_PRIO_EN
    logic [3:0] starve_q, starve_d;
`else
    port_t last_grant_q, last_grant_d;
`endif

    logic        a_gnt;
    logic        b_gnt;
    logic        any_gnt;
    logic        sel_we;
    logic        in_range;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    // Arbitration: choose at most one port to grant this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            if (bus.b_req && (starve_q == 4'd15)) begin
                b_gnt = 1'b1;
            end else if (bus.a_req) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = bus.b_req;
            end
`else
            if (bus.a_req && bus.b_req) begin
                a_gnt = (last_grant_q == PORT_B);
                b_gnt = (last_grant_q == PORT_A);
            end else begin
                a_gnt = bus.a_req;
                b_gnt = bus.b_req;
            end
`endif
        end
    end

    // Memory drive: route the granted port onto the memory bus.
    always_comb begin
        any_gnt   = a_gnt | b_gnt;
        sel_we    = b_gnt ? bus.b_we    : bus.a_we;
        sel_addr  = b_gnt ? bus.b_addr  : bus.a_addr;
        sel_wdata = b_gnt ? bus.b_wdata : bus.a_wdata;
        // Byte address bit 0 is ignored; only the word index is range-checked.
        in_range  = ({1'b0, sel_addr[15:1]} < WORD_LIMIT);

        bus.mem_address    = any_gnt ? sel_addr  : 16'h0000;
        bus.mem_write_data = any_gnt ? sel_wdata : 16'h0000;
        bus.mem_write      = any_gnt & in_range & sel_we;
        bus.mem_read       = any_gnt & in_range & ~sel_we;
    end

    // Next-state: any grant schedules a response for the following cycle.
    always_comb begin
        state_d    = any_gnt ? ST_RESP : ST_IDLE;
        owner_d    = b_gnt ? PORT_B : PORT_A;
        resp_rd_d  = any_gnt & ~sel_we;
        resp_err_d = any_gnt & ~in_range;
`ifdef DMEM_ARB_CPU_PRIO_EN
        starve_d = starve_q;
        if (b_gnt) begin
            starve_d = 4'd0;
        end else if (bus.b_req) begin
            starve_d = starve_q + 4'd1;
        end
`else
        last_grant_d = any_gnt ? owner_d : last_grant_q;
`endif
    end

    // State registers with synchronous reset; pending responses are dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking assignments.
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_A;
            resp_rd_q    <= 1'b0;
            resp_err_q   <= 1'b0;
`ifdef DMEM_ARB_CPU_PRIO_EN
            starve_q     <= 4'd0;
`else
            last_grant_q <= port_t'(RR_INIT);
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
`ifdef DMEM_ARB_CPU_PRIO_EN
            starve_q     <= starve_d;
`else
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Response outputs: forced to 0 while rst is held.
    logic resp_a;
    logic resp_b;
    logic resp_data_ok;

    always_comb begin
        resp_a       = ~rst & (state_q == ST_RESP) & (owner_q == PORT_A);
        resp_b       = ~rst & (state_q == ST_RESP) & (owner_q == PORT_B);
        resp_data_ok = resp_rd_q & ~resp_err_q;

        bus.a_gnt    = a_gnt;
        bus.b_gnt    = b_gnt;
        bus.a_rvalid = resp_a & resp_rd_q;
        bus.b_rvalid = resp_b & resp_rd_q;
        bus.a_err    = resp_a & resp_err_q;
        bus.b_err    = resp_b & resp_err_q;
        bus.a_rdata  = (resp_a & resp_data_ok) ? bus.mem_read_data : 16'h0000;
        bus.b_rdata  = (resp_b & resp_data_ok) ? bus.mem_read_data : 16'h0000;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. A behavioural model
// (arbitration rule, pending-response record and a shadow copy of memory)
// is checked against the DUT on every falling edge; directed sequences add
// hand-computed literal expectations. The memory itself is a small
// environment model that preloads word i with value i while rst is high.
module tb_dmem_arbiter;

    localparam int MEM_WORDS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .MEM_WORDS (MEM_WORDS),
        .RR_INIT   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- memory environment ----------------
    logic [15:0] mem [0:MEM_WORDS-1];
    logic [15:0] mem_rd_q = 16'h0000;
    assign bus.mem_read_data = mem_rd_q;

    always @(posedge clk) begin
        mem_rd_q <= bus.mem_read ? mem[bus.mem_address[6:1]] : 16'h0000;
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 16'(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_address[6:1]] <= bus.mem_write_data;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_last = 1'b1;        // port granted most recently (1 = B)
    logic        m_pv   = 1'b0;        // a response is due next cycle
    logic        m_po   = 1'b0;        // its owner (1 = B)
    logic        m_pr   = 1'b0;        // it is a read
    logic        m_pe   = 1'b0;        // it is out of range
    logic [15:0] m_pd   = 16'h0000;    // data it must return
    int          m_wait = 0;           // consecutive cycles B waited
    logic [15:0] model_mem [0:MEM_WORDS-1];

    always @(negedge clk) begin : model_cmp
        logic        ga, gb, we, oor;
        logic [15:0] addr, wd;
        int          word;
        if (rst) begin
            check_bit("rst a_gnt", bus.a_gnt, 1'b0);
            check_bit("rst b_gnt", bus.b_gnt, 1'b0);
            check_bit("rst mem_read", bus.mem_read, 1'b0);
            check_bit("rst mem_write", bus.mem_write, 1'b0);
            check16("rst mem_address", bus.mem_address, 16'h0000);
            check16("rst mem_write_data", bus.mem_write_data, 16'h0000);
            check_bit("rst a_rvalid", bus.a_rvalid, 1'b0);
            check_bit("rst b_rvalid", bus.b_rvalid, 1'b0);
            check_bit("rst a_err", bus.a_err, 1'b0);
            check_bit("rst b_err", bus.b_err, 1'b0);
            check16("rst a_rdata", bus.a_rdata, 16'h0000);
            check16("rst b_rdata", bus.b_rdata, 16'h0000);
            m_pv   = 1'b0;
            m_last = 1'b1;
            m_wait = 0;
            for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 16'(i);
        end else begin
            // Response owed from last cycle's grant.
            check_bit("model a_rvalid", bus.a_rvalid, m_pv && !m_po && m_pr);
            check_bit("model b_rvalid", bus.b_rvalid, m_pv &&  m_po && m_pr);
            check_bit("model a_err", bus.a_err, m_pv && !m_po && m_pe);
            check_bit("model b_err", bus.b_err, m_pv &&  m_po && m_pe);
            check16("model a_rdata", bus.a_rdata, (m_pv && !m_po && m_pr) ? m_pd : 16'h0000);
            check16("model b_rdata", bus.b_rdata, (m_pv &&  m_po && m_pr) ? m_pd : 16'h0000);

            // Who should win now.
`ifdef DMEM_ARB_CPU_PRIO_EN
            gb = bus.b_req && (m_wait >= 15 || !bus.a_req);
            ga = bus.a_req && !gb;
`else
            if (bus.a_req && bus.b_req) begin
                ga = m_last;
                gb = !m_last;
            end else begin
                ga = bus.a_req;
                gb = bus.b_req;
            end
`endif
            check_bit("model a_gnt", bus.a_gnt, ga);
            check_bit("model b_gnt", bus.b_gnt, gb);

            if (ga || gb) begin
                addr = ga ? bus.a_addr  : bus.b_addr;
                we   = ga ? bus.a_we    : bus.b_we;
                wd   = ga ? bus.a_wdata : bus.b_wdata;
                word = int'(addr) / 2;
                oor  = (word >= MEM_WORDS);
                check_bit("model mem_read", bus.mem_read, !oor && !we);
                check_bit("model mem_write", bus.mem_write, !oor && we);
                check16("model mem_address", bus.mem_address, addr);
                check16("model mem_write_data", bus.mem_write_data, wd);
                m_pv = 1'b1;
                m_po = gb;
                m_pr = !we;
                m_pe = oor;
                m_pd = (oor || we) ? 16'h0000 : model_mem[word];
                if (we && !oor) model_mem[word] = wd;
                m_last = gb;
            end else begin
                check_bit("model idle mem_read", bus.mem_read, 1'b0);
                check_bit("model idle mem_write", bus.mem_write, 1'b0);
                m_pv = 1'b0;
            end

            if (gb) m_wait = 0;
            else if (bus.b_req) m_wait = m_wait + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_a(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        bus.a_req   = req;
        bus.a_we    = we;
        bus.a_addr  = addr;
        bus.a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        bus.b_req   = req;
        bus.b_we    = we;
        bus.b_addr  = addr;
        bus.b_wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Watchdog: the sequence below is fixed-length, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int   ai, bi, prev_word;
        logic prev_is_a;

        rst = 1'b1;
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_b(1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset with both ports requesting: nothing may be granted.
        step();
        drive_a(1'b1, 1'b0, 16'h0004, 16'h0000);
        drive_b(1'b1, 1'b0, 16'h0006, 16'h0000);
        settle();
        check16("reset grants", 16'({bus.a_gnt, bus.b_gnt}), 16'h0000);
        check16("reset mem_address", bus.mem_address, 16'h0000);
        step();
        rst = 1'b0;
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_b(1'b0, 1'b0, 16'h0000, 16'h0000);

        // A writes 0xBEEF to 0x0010, then reads it back.
        step();
        drive_a(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        settle();
        check_bit("wr a_gnt", bus.a_gnt, 1'b1);
        check_bit("wr mem_write", bus.mem_write, 1'b1);
        check16("wr mem_address", bus.mem_address, 16'h0010);
        step();
        drive_a(1'b1, 1'b0, 16'h0010, 16'h0000);
        settle();
        check_bit("rd a_gnt", bus.a_gnt, 1'b1);
        check_bit("rd mem_read", bus.mem_read, 1'b1);
        check_bit("wr no rvalid", bus.a_rvalid, 1'b0);
        step();
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check_bit("rd a_rvalid", bus.a_rvalid, 1'b1);
        check16("rd a_rdata", bus.a_rdata, 16'hBEEF);

        // B reads word 64 (out of range).
        step();
        drive_b(1'b1, 1'b0, 16'h0080, 16'h0000);
        settle();
        check_bit("oor b_gnt", bus.b_gnt, 1'b1);
        check_bit("oor mem_read", bus.mem_read, 1'b0);
        step();
        drive_b(1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check_bit("oor b_err", bus.b_err, 1'b1);
        check_bit("oor b_rvalid", bus.b_rvalid, 1'b1);
        check16("oor b_rdata", bus.b_rdata, 16'h0000);
        check_bit("oor a_rvalid", bus.a_rvalid, 1'b0);

`ifndef DMEM_ARB_CPU_PRIO_EN
        // Both ports read every cycle: A words 1..3, B words 20..22.
        // Last grant was B, so A wins first and grants alternate.
        ai = 0;
        bi = 0;
        prev_is_a = 1'b0;
        prev_word = 0;
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k < 6) begin
                drive_a(1'b1, 1'b0, 16'(2 * (1 + ai)), 16'h0000);
                drive_b(1'b1, 1'b0, 16'(2 * (20 + bi)), 16'h0000);
            end else begin
                drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
                drive_b(1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            settle();
            if (k < 6) begin
                check_bit("rr a_gnt", bus.a_gnt, (k % 2) == 0);
                check_bit("rr b_gnt", bus.b_gnt, (k % 2) == 1);
            end
            if (k > 0) begin
                check_bit("rr a_rvalid", bus.a_rvalid, prev_is_a);
                check_bit("rr b_rvalid", bus.b_rvalid, !prev_is_a);
                check16("rr rdata", prev_is_a ? bus.a_rdata : bus.b_rdata, 16'(prev_word));
                check16("rr other rdata", prev_is_a ? bus.b_rdata : bus.a_rdata, 16'h0000);
            end
            if (k < 6) begin
                if ((k % 2) == 0) begin
                    prev_is_a = 1'b1;
                    prev_word = 1 + ai;
                    ai++;
                end else begin
                    prev_is_a = 1'b0;
                    prev_word = 20 + bi;
                    bi++;
                end
            end
        end
`endif

        // A read granted, then rst: the response must be dropped.
        step();
        drive_a(1'b1, 1'b0, 16'h0004, 16'h0000);
        settle();
        check_bit("pre-rst a_gnt", bus.a_gnt, 1'b1);
        step();
        rst = 1'b1;
        drive_a(1'b1, 1'b0, 16'h0004, 16'h0000);
        drive_b(1'b1, 1'b0, 16'h0008, 16'h0000);
        settle();
        check_bit("mid-rst a_rvalid", bus.a_rvalid, 1'b0);
        check16("mid-rst a_rdata", bus.a_rdata, 16'h0000);
        check_bit("mid-rst a_gnt", bus.a_gnt, 1'b0);
        check_bit("mid-rst mem_read", bus.mem_read, 1'b0);
        step();
        rst = 1'b0;
        settle();
        check_bit("post-rst tie a_gnt", bus.a_gnt, 1'b1);
        check_bit("post-rst tie b_gnt", bus.b_gnt, 1'b0);
        check_bit("post-rst a_rvalid", bus.a_rvalid, 1'b0);
        step();
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check_bit("post-rst b_gnt", bus.b_gnt, 1'b1);
        check16("post-rst a_rdata", bus.a_rdata, 16'h0002);
        step();
        drive_b(1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check16("post-rst b_rdata", bus.b_rdata, 16'h0004);

        // Back-to-back write then read of the same word.
        step();
        drive_a(1'b1, 1'b1, 16'h0006, 16'h1234);
        settle();
        check_bit("b2b wr a_gnt", bus.a_gnt, 1'b1);
        step();
        drive_a(1'b1, 1'b0, 16'h0006, 16'h0000);
        settle();
        check_bit("b2b rd a_gnt", bus.a_gnt, 1'b1);
        step();
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check_bit("b2b a_rvalid", bus.a_rvalid, 1'b1);
        check16("b2b a_rdata", bus.a_rdata, 16'h1234);

        // Last word with address bit 0 set, then a write just past the end.
        step();
        drive_a(1'b1, 1'b0, 16'h007F, 16'h0000);
        settle();
        check_bit("w63 mem_read", bus.mem_read, 1'b1);
        check16("w63 mem_address", bus.mem_address, 16'h007F);
        step();
        drive_a(1'b1, 1'b1, 16'h0080, 16'hDEAD);
        settle();
        check_bit("oorw a_gnt", bus.a_gnt, 1'b1);
        check_bit("oorw mem_write", bus.mem_write, 1'b0);
        check16("w63 a_rdata", bus.a_rdata, 16'd63);
        check_bit("w63 a_err", bus.a_err, 1'b0);
        step();
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        settle();
        check_bit("oorw a_err", bus.a_err, 1'b1);
        check_bit("oorw a_rvalid", bus.a_rvalid, 1'b0);

`ifdef DMEM_ARB_CPU_PRIO_EN
        // Continuous contention: 15 A grants, then one B grant, repeating.
        for (int k = 0; k < 32; k++) begin
            step();
            drive_a(1'b1, 1'b0, 16'h0002, 16'h0000);
            drive_b(1'b1, 1'b0, 16'h0004, 16'h0000);
            settle();
            check_bit("prio b_gnt", bus.b_gnt, (k % 16) == 15);
            check_bit("prio a_gnt", bus.a_gnt, (k % 16) != 15);
        end
        step();
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_b(1'b0, 1'b0, 16'h0000, 16'h0000);
`endif

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port, 64-word, 16-bit data memory.
- Port A is the CPU load/store path. Port B is the DMA/debug path.
- Grants one access per cycle, drives the memory strobes, and tracks the 1-cycle synchronous read latency.
- Returns read data and an out-of-range error to whichever requester owns each access.

Parameters:
- MEM_WORDS, 64: number of 16-bit words in the memory; range limit for word index address[15:1].
- RR_INIT, 1: last-grant pointer value after reset (1 = B, so A wins the first tie).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a_req  input  1  port A request; held until a_gnt.
- a_we  input  1  port A: 1 = write, 0 = read.
- a_addr  input  16  port A byte address; word index = a_addr[15:1].
- a_wdata  input  16  port A write data.
- a_gnt  output  1  port A access accepted this cycle (combinational).
- a_rvalid  output  1  port A read data / error valid, one cycle after a read grant.
- a_rdata  output  16  port A read data.
- a_err  output  1  port A out-of-range flag, one cycle after grant.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: same as port A, for port B.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_address  output  16  memory address (byte address, passed through).
- mem_write_data  output  16  memory write data.
- mem_read_data  input  16  memory read data; 1-cycle registered; 0 when not read.

Behaviour:
- Reset: while rst=1:
  - a_gnt, b_gnt, mem_read, mem_write all 0.
  - mem_address and mem_write_data are 0.
  - On the clock edge, the rvalid/err pipeline registers clear to 0 and last_grant loads RR_INIT.
  - All *_rvalid, *_err and *_rdata outputs read 0.
- Arbitration each cycle (combinational):
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the port that is not last_grant (round-robin).
  - last_grant updates on the edge of every grant.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt high.
  - A grant completes the request phase in the same cycle.
  - The requester may issue a new request in the following cycle; back-to-back grants are allowed every cycle.
- Memory drive in a grant cycle:
  - mem_address and mem_write_data come from the granted port.
  - mem_write = we. mem_read = ~we.
  - Both strobes are 0 if the word index (addr[15:1]) >= MEM_WORDS.
- Pipeline state machine:
  - IDLE: no response pending.
  - RESP: response due this cycle; the owner is registered.
  - Any grant moves to RESP for the next cycle, else to IDLE.
  - RESP and a new grant coexist, so the pipeline is fully overlapped.
- Response, one cycle after grant:
  - Read grant: owner's rvalid=1 and rdata=mem_read_data; the other port's rdata=0.
  - Write grant: no rvalid. The write takes effect at the grant edge.
  - Out-of-range grant: owner's err=1 for one cycle; for a read, rvalid=1 and rdata=0. Memory is untouched.
- Byte address bit 0 is ignored; no misalignment error is raised.
- Reset mid-operation: a read granted in the cycle before rst produces no rvalid. Pending state is discarded.
- Read-after-write to the same word in consecutive cycles returns the new data, because the memory write and read are ordered on successive edges.

Optional Feature:
- Macro: DMEM_ARB_CPU_PRIO_EN.
- Defined:
  - Fixed priority; port A always wins when both ports request.
  - A 4-bit starvation counter increments each cycle B requests and is not granted.
  - When the counter reaches 15, B is granted once and the counter clears.
  - The counter also clears on any B grant and on rst.
- Undefined: round-robin as described under Behaviour; no counter is built.

Test Plan:
- Reset, then A writes 0xBEEF to addr 0x0010 → a_gnt=1 that cycle with mem_write=1 and mem_address=0x0010. Then A reads 0x0010 → a_rvalid=1 and a_rdata=0xBEEF one cycle after the read grant.
- A and B both request reads every cycle for 6 cycles → grants alternate A,B,A,B,A,B. Each rvalid goes only to the owner, with rdata = word index (preloaded contents).
- B reads addr 0x0080 (word 64, out of range) → b_gnt=1 with mem_read=0. Next cycle b_err=1, b_rvalid=1, b_rdata=0.
- A reads 0x0004 and rst is asserted the next cycle → a_rvalid stays 0. All outputs are 0 during rst. After reset, A wins the first tie.
- Back-to-back: A writes 0x1234 to 0x0006, then reads 0x0006 in the next cycle → a_rvalid with a_rdata=0x1234 two cycles after the write grant.
- With DMEM_ARB_CPU_PRIO_EN defined, A and B request continuously → A is granted for 15 cycles, B is granted on the 16th, and the pattern repeats.
